// File: rtl/note_finder_feeder.sv
// Transmit side of the NoteFinder frame interface: gathers a serial stream of
// DFT bins into a fill buffer and launches whole frames as a registered bus.
module note_finder_feeder #(
  parameter int N       = 16,
  parameter int BPO     = 24,
  parameter int OCT     = 5,
  parameter int TIMEOUT = 2048,
  parameter int CW      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   binIn,
  input  logic                           binValid,
  output logic                           binReady,
  output logic [BPO*OCT*N-1:0]           dftBins,
  output logic                           startCycle,
  input  logic                           nfFinished,
  output logic [$clog2(BPO*OCT+1)-1:0]   fillCount,
  output logic [CW-1:0]                  frameCount,
  output logic                           timeoutErr
);

  localparam int BINS = BPO * OCT;
  localparam int FW   = $clog2(BINS + 1);
  localparam int AW   = $clog2(BINS);
  localparam int WW   = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(BINS - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_alive;
  logic                r_full;
  logic [FW-1:0]       r_fill_cnt;
  logic [WW-1:0]       r_wdog;
  logic [N-1:0]        r_fill_buf [BINS];
  logic [BINS*N-1:0]   r_dft;
  logic                r_start;
  logic [CW-1:0]       r_frame_cnt;
  logic                r_tmo;
  logic                w_take;
  logic                w_launch;
  logic                w_wd_expire;

  assign binReady   = r_alive && !r_full;
  assign w_take     = binValid && binReady;
  assign dftBins    = r_dft;
  assign startCycle = r_start;
  assign fillCount  = r_fill_cnt;
  assign frameCount = r_frame_cnt;
  assign timeoutErr = r_tmo;

  // A finished pulse takes priority over a watchdog expiry on the same edge.
  always_comb begin
    w_launch    = r_full && ((r_state == S_IDLE) || nfFinished);
    w_wd_expire = (r_state == S_WAIT) && !nfFinished && (r_wdog == WD_LAST);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_full) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (nfFinished)       w_state_nxt = r_full ? S_WAIT : S_IDLE;
        else if (w_wd_expire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Fill buffer holds data only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_take) r_fill_buf[r_fill_cnt[AW-1:0]] <= binIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive     <= 1'b0;
      r_full      <= 1'b0;
      r_fill_cnt  <= '0;
      r_wdog      <= '0;
      r_start     <= 1'b0;
      r_frame_cnt <= '0;
      r_tmo       <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      r_start <= w_launch;
      if (w_launch) begin
        r_full      <= 1'b0;
        r_fill_cnt  <= '0;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end else if (w_take) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (r_fill_cnt == FILL_LAST) r_full <= 1'b1;
      end
      if (w_launch || w_wd_expire || nfFinished || (r_state == S_IDLE))
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + 1'b1;
      if (w_wd_expire) r_tmo <= 1'b1;
    end
  end

  // The whole frame moves to the output bus in a single edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dft <= '0;
    end else if (w_launch) begin
      for (int k = 0; k < BINS; k++) r_dft[k*N +: N] <= r_fill_buf[k];
    end
  end

endmodule

// File: tb/tb_note_finder_feeder.sv
// Directed bench for note_finder_feeder: launched frames are checked against a
// queue of frames assembled from the driven stimulus.
module tb_note_finder_feeder;

  localparam int N       = 16;
  localparam int BINS    = 120;
  localparam int FW      = 7;
  localparam int CW      = 16;
  localparam int TIMEOUT = 2048;
  localparam int FIN_DLY = 400;
  localparam int NFRAMES = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        binIn = '0;
  logic                binValid = 1'b0;
  logic                binReady;
  logic [BINS*N-1:0]   dftBins;
  logic                startCycle;
  logic                nfFinished = 1'b0;
  logic [FW-1:0]       fillCount;
  logic [CW-1:0]       frameCount;
  logic                timeoutErr;

  note_finder_feeder #(.N(N), .BPO(24), .OCT(5), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .binIn(binIn), .binValid(binValid), .binReady(binReady),
    .dftBins(dftBins), .startCycle(startCycle), .nfFinished(nfFinished),
    .fillCount(fillCount), .frameCount(frameCount), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                n_starts = 0;
  int                last_start_cyc = 0;
  int                fin_cnt = 0;
  bit                auto_fin = 1'b0;
  bit                prev_start = 1'b0;
  logic [BINS*N-1:0] last_dft = '0;
  logic [BINS*N-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [BINS*N-1:0] obs,
                           input logic [BINS*N-1:0] expv);
    int bad;
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      bad = 0;
      for (int k = BINS - 1; k >= 0; k--)
        if (obs[k*N +: N] !== expv[k*N +: N]) bad = k;
      $error("FAIL %s: bin %0d got %0h expected %0h", tag, bad, obs[bad*N +: N], expv[bad*N +: N]);
    end
  endtask

  // One clock: wait for the edge, then sample outputs 1 time unit later.
  task automatic tick();
    logic [BINS*N-1:0] exp_f;
    @(posedge clk);
    #1;
    cyc++;
    if (startCycle) begin
      n_starts++;
      last_start_cyc = cyc;
      chk("start_not_adjacent", 32'(prev_start), 32'd0);
      chk("start_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_f = sb_q.pop_front();
        chk_frame("launch_frame", dftBins, exp_f);
      end
    end else begin
      chk_frame("dft_stable", dftBins, last_dft);
    end
    last_dft   = dftBins;
    prev_start = startCycle;
    if (auto_fin) begin
      nfFinished = 1'b0;
      if (startCycle) fin_cnt = FIN_DLY;
      else if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) nfFinished = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    binValid = 1'b0;
    nfFinished = 1'b0;
    auto_fin = 1'b0;
    sb_q.delete();
    last_dft = '0;
    prev_start = 1'b0;
    #2;
    chk("rst_dft", 32'(dftBins == '0), 32'd1);
    chk("rst_start", 32'(startCycle), 32'd0);
    chk("rst_fill", 32'(fillCount), 32'd0);
    chk("rst_frames", 32'(frameCount), 32'd0);
    chk("rst_tmo", 32'(timeoutErr), 32'd0);
    chk("rst_ready", 32'(binReady), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_start_edge", 32'(startCycle), 32'd0);
    rst = 1'b1;
    chk("ready_before_edge", 32'(binReady), 32'd0);
    tick();
    chk("ready_after_edge", 32'(binReady), 32'd1);
  endtask

  task automatic send_bin(input logic [N-1:0] v);
    bit was_ready;
    int budget;
    binValid = 1'b1;
    binIn = v;
    budget = 5000;
    do begin
      was_ready = binReady;
      tick();
      budget--;
    end while (!was_ready && budget > 0);
    if (!was_ready) chk("bin_accept_timeout", 32'(was_ready), 32'd1);
  endtask

  task automatic send_frame(input int kind, input bit gap);
    logic [BINS*N-1:0] f;
    logic [N-1:0]      v;
    for (int k = 0; k < BINS; k++) begin
      case (kind)
        0:       v = N'(k + 1);
        1:       v = N'(16'h100 + k);
        2:       v = N'(16'h200 + k);
        3:       v = N'(16'h300 + k);
        4:       v = N'(7);
        default: v = N'($urandom_range(0, 65535));
      endcase
      send_bin(v);
      f[k*N +: N] = v;
      if (gap) begin
        binValid = 1'b0;
        tick();
        tick();
      end
    end
    binValid = 1'b0;
    sb_q.push_back(f);
  endtask

  task automatic pulse_fin();
    nfFinished = 1'b1;
    tick();
    nfFinished = 1'b0;
  endtask

  initial begin
    int s0;
    int budget;
    #1;
    do_reset();

    // Frame A streamed back to back with the source always valid.
    send_frame(0, 1'b0);
    chk("a_ready_full", 32'(binReady), 32'd0);
    chk("a_fill_full", 32'(fillCount), 32'd120);
    chk("a_no_start_e0", 32'(startCycle), 32'd0);
    tick();
    chk("a_start", 32'(startCycle), 32'd1);
    chk("a_frames", 32'(frameCount), 32'd1);
    chk("a_fill_zero", 32'(fillCount), 32'd0);
    chk("a_ready_back", 32'(binReady), 32'd1);
    chk("a_bin0", 32'(dftBins[0 +: N]), 32'd1);
    chk("a_bin119", 32'(dftBins[119*N +: N]), 32'd120);
    tick();
    chk("a_start_one_cycle", 32'(startCycle), 32'd0);

    // Frame B fills while A is outstanding and must wait for finished.
    send_frame(1, 1'b0);
    binValid = 1'b1;
    binIn = 16'hdead;
    for (int i = 0; i < 5; i++) tick();
    chk("b_ready_stall", 32'(binReady), 32'd0);
    chk("b_fill_held", 32'(fillCount), 32'd120);
    chk("b_dft_still_a", 32'(dftBins[0 +: N]), 32'd1);
    chk("b_pending", 32'(sb_q.size()), 32'd1);
    binValid = 1'b0;
    pulse_fin();
    chk("b_start_on_fin", 32'(startCycle), 32'd1);
    chk("b_frames", 32'(frameCount), 32'd2);
    chk("b_bin0", 32'(dftBins[0 +: N]), 32'h100);

    // Frame C: finished arrives on the very edge that first sees it full.
    send_frame(2, 1'b0);
    pulse_fin();
    chk("c_start", 32'(startCycle), 32'd1);
    chk("c_frames", 32'(frameCount), 32'd3);
    send_frame(3, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("d_held_busy", 32'(sb_q.size()), 32'd1);
    pulse_fin();
    chk("d_frames", 32'(frameCount), 32'd4);
    pulse_fin();
    pulse_fin();
    chk("idle_fin_ignored", 32'(n_starts), 32'd4);
    send_frame(5, 1'b0);
    tick();
    chk("e_idle_launch", 32'(n_starts), 32'd5);
    chk("e_frames", 32'(frameCount), 32'd5);

    // Frame E never finishes; F waits behind the watchdog.
    s0 = n_starts;
    send_frame(5, 1'b0);
    budget = 3000;
    while (!timeoutErr && budget > 0) begin
      tick();
      budget--;
    end
    chk("tmo_seen", 32'(timeoutErr), 32'd1);
    chk("tmo_cycles", 32'(cyc - last_start_cyc), 32'd2048);
    chk("tmo_no_early_launch", 32'(n_starts), 32'(s0));
    chk("tmo_start_low", 32'(startCycle), 32'd0);
    tick();
    chk("f_launch_after_tmo", 32'(startCycle), 32'd1);
    chk("f_frames", 32'(frameCount), 32'd6);
    tick();
    chk("tmo_sticky", 32'(timeoutErr), 32'd1);

    // Partial frame discarded by a reset in the middle of filling.
    do_reset();
    for (int k = 0; k < 60; k++) send_bin(16'h55);
    binValid = 1'b0;
    chk("partial_fill", 32'(fillCount), 32'd60);
    do_reset();
    send_frame(4, 1'b0);
    tick();
    chk("r_start", 32'(startCycle), 32'd1);
    chk("r_frames", 32'(frameCount), 32'd1);
    chk("r_bin0", 32'(dftBins[0 +: N]), 32'd7);
    chk("r_bin119", 32'(dftBins[119*N +: N]), 32'd7);

    // Gapped source with a NoteFinder that answers after a fixed delay.
    s0 = n_starts;
    auto_fin = 1'b1;
    fin_cnt = FIN_DLY;
    for (int f = 0; f < NFRAMES; f++) send_frame(5, 1'b1);
    budget = 2000;
    while (sb_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("g_drained", 32'(sb_q.size()), 32'd0);
    chk("g_starts", 32'(n_starts - s0), 32'(NFRAMES));
    chk("g_frames", 32'(frameCount), 32'(NFRAMES + 1));
    chk("g_tmo_clear", 32'(timeoutErr), 32'd0);
    auto_fin = 1'b0;
    nfFinished = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
